// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit registered ALU.
// Build option: ALU_SATURATE_EN makes ADD clamp at 4'hF and SUB clamp at 4'h0.
// When the macro is not defined, ADD and SUB wrap modulo 16.
package alu_pkg;

  // Result and operand width.
  localparam int ALU_W = 4;

  // Operation select encoding: ADD=00, SUB=01, AND=10, XOR=11.
  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_XOR
  } alu_op_e;

  // Clamp values used when saturation is compiled in.
  localparam logic [ALU_W-1:0] ALU_SAT_MAX = '1;
  localparam logic [ALU_W-1:0] ALU_SAT_MIN = '0;

  // Resolve the build option into a constant so the datapath is written once.
  // Both builds then use the fifth arithmetic bit.
`ifdef ALU_SATURATE_EN
  localparam bit ALU_SAT_EN = 1'b1;
`else
  localparam bit ALU_SAT_EN = 1'b0;
`endif

  // Zero-extend an operand to the internal arithmetic width.
  function automatic logic [ALU_W:0] alu_ext(input logic [ALU_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational datapath of the ALU: produces the next result from a, b, op and c.
// Build option: ALU_SATURATE_EN (resolved in alu_pkg) selects clamping instead of
// modulo-16 wrap for ADD and SUB.
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  alu_op_e          op_i,
  input  logic             c_i,
  output logic [ALU_W-1:0] res_o
);

  // Five-bit intermediates. Bit 4 is the carry-out for ADD. For SUB it is the
  // borrow-out: a - b - c is negative exactly when the 5-bit difference has bit 4 set.
  logic [ALU_W:0] sum_w;
  logic [ALU_W:0] diff_w;
  logic [ALU_W:0] cin_w;

  assign cin_w  = {{ALU_W{1'b0}}, c_i};
  assign sum_w  = alu_ext(a_i) + alu_ext(b_i) + cin_w;
  assign diff_w = alu_ext(a_i) - alu_ext(b_i) - cin_w;

  // Select the operation result, clamping arithmetic overflow when saturation is built in.
  always_comb begin
    res_o = '0;
    unique case (op_i)
      OP_ADD: res_o = (ALU_SAT_EN && sum_w[ALU_W])  ? ALU_SAT_MAX : sum_w[ALU_W-1:0];
      OP_SUB: res_o = (ALU_SAT_EN && diff_w[ALU_W]) ? ALU_SAT_MIN : diff_w[ALU_W-1:0];
      OP_AND: res_o = a_i & b_i;
      OP_XOR: res_o = a_i ^ b_i;
      default: res_o = '0;
    endcase
  end

endmodule : alu_core

// File: rtl/alu_modport.sv
// Top level of the 4-bit registered ALU: the combinational core plus one
// asynchronously reset result register. The latency is one cycle.
// Build option: ALU_SATURATE_EN (see alu_pkg) makes ADD and SUB saturate.
module alu_modport
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [1:0]       op,
  input  logic             c,
  output logic [ALU_W-1:0] out
);

  logic [ALU_W-1:0] out_d;
  logic [ALU_W-1:0] out_q;

  alu_core u_core (
    .a_i   (a),
    .b_i   (b),
    .op_i  (alu_op_e'(op)),
    .c_i   (c),
    .res_o (out_d)
  );

  // Capture a new result on every edge; reset clears it at once, without waiting for the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : alu_modport

// File: tb/tb_alu_modport.sv
// Self-checking bench for alu_modport. It pushes expected results into a
// scoreboard queue when it drives inputs, then pops and compares them one
// step after the capturing edge.
module tb_alu_modport;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [1:0] op = '0;
  logic       c = 1'b0;
  logic [3:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] XOR = 2'b11;

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_modport dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .c     (c),
    .out   (out)
  );

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: out=%0d", tag, got);
    end
  endtask

  // Reference model written from the operation table using integer arithmetic.
  function automatic logic [3:0] model(input int ai, input int bi, input logic [1:0] o, input int ci);
    int r;
    case (o)
      ADD: begin
        r = ai + bi + ci;
        if (SAT && r > 15) r = 15;
      end
      SUB: begin
        r = ai - bi - ci;
        if (SAT && r < 0) r = 0;
      end
      AND: r = ai & bi;
      default: r = ai ^ bi;
    endcase
    r = (r + 32) % 16;
    return r[3:0];
  endfunction

  // Drive one operation, queue its expected result, then check it after the capturing edge.
  task automatic do_op(input logic [3:0] ai, input logic [3:0] bi, input logic [1:0] oi,
                       input logic ci, input logic [3:0] e, input string t);
    logic [3:0] exp_v;
    string      tag_v;
    @(negedge clk);
    a = ai; b = bi; op = oi; c = ci;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    tag_v = tag_q.pop_front();
    check_eq(tag_v, out, exp_v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra, rb;
    logic [1:0] ro;
    logic       rc;

    // Assert reset between edges and check that it clears the output at once.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_init", out, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold", out, 4'h0);

    // Release reset; the first edge with rst_n high captures 2+3.
    @(negedge clk);
    a = 4'd2; b = 4'd3; op = ADD; c = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_release_add", out, 4'd5);

    // ADD cases.
    do_op(4'd7, 4'd5, ADD, 1'b1, 4'd13, "add_7_5_c1");

    // Reset between edges while out=D: it clears at once and discards the pending result.
    #2;
    a = 4'd1; b = 4'd1; op = ADD; c = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_mid", out, 4'h0);
    @(posedge clk);
    #1;
    check_eq("rst_discard", out, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(4'd15, 4'd1, ADD, 1'b0, SAT ? 4'd15 : 4'd0, "add_15_1_wrap");
    do_op(4'd15, 4'd15, ADD, 1'b1, SAT ? 4'd15 : 4'd15, "add_15_15_c1");
    do_op(4'd8, 4'd8, ADD, 1'b0, SAT ? 4'd15 : 4'd0, "add_8_8");

    // SUB cases.
    do_op(4'd9, 4'd4, SUB, 1'b1, 4'd4, "sub_9_4_c1");
    do_op(4'd3, 4'd5, SUB, 1'b0, SAT ? 4'd0 : 4'd14, "sub_3_5_wrap");
    do_op(4'd0, 4'd0, SUB, 1'b1, SAT ? 4'd0 : 4'd15, "sub_0_0_c1");

    // Logic operations: c must not affect them.
    do_op(4'hC, 4'hA, AND, 1'b0, 4'h8, "and_c0");
    do_op(4'hC, 4'hA, XOR, 1'b0, 4'h6, "xor_c0");
    do_op(4'hC, 4'hA, AND, 1'b1, 4'h8, "and_c1");
    do_op(4'hC, 4'hA, XOR, 1'b1, 4'h6, "xor_c1");

    // Back-to-back, with the op changing every cycle.
    do_op(4'd6, 4'd3, ADD, 1'b0, 4'd9, "b2b_add");
    do_op(4'd6, 4'd3, SUB, 1'b0, 4'd3, "b2b_sub");
    do_op(4'd6, 4'd3, AND, 1'b0, 4'd2, "b2b_and");
    do_op(4'd6, 4'd3, XOR, 1'b0, 4'd5, "b2b_xor");

    // Random operations checked against the model.
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      ro = 2'($urandom_range(0, 3));
      rc = 1'($urandom_range(0, 1));
      do_op(ra, rb, ro, rc, model(int'(ra), int'(rb), ro, int'(rc)),
            $sformatf("rand_%0d_op%0d_%0d_%0d_c%0d", i, ro, ra, rb, rc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_modport
